// File: rtl/led_controller.sv
// Multi-channel LED driver: each channel is OFF, ON, BLINK or PWM, configured over valid/ready.
// Define LED_CONTROLLER_BREATHE_EN to make PWM channels ramp their duty up and down per tick.
module led_controller #(
  parameter int unsigned NumLeds        = 4,
  parameter int unsigned PrescaleCycles = 1_000_000,
  parameter int unsigned PeriodWidth    = 16,
  parameter int unsigned DutyWidth      = 8,
  localparam int unsigned ChanWidth     = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [ChanWidth-1:0]   cfg_chan_i,
  input  logic [1:0]             cfg_mode_i,
  input  logic [PeriodWidth-1:0] cfg_period_i,
  input  logic [DutyWidth-1:0]   cfg_duty_i,
  output logic                   tick_o,
  output logic [NumLeds-1:0]     led_o
);

  localparam int unsigned PresWidth = (PrescaleCycles > 1) ? $clog2(PrescaleCycles) : 1;
  localparam logic [PresWidth-1:0] PresMax = PresWidth'(PrescaleCycles - 1);

  localparam logic [1:0] ModeOff   = 2'd0;
  localparam logic [1:0] ModeOn    = 2'd1;
  localparam logic [1:0] ModeBlink = 2'd2;
  localparam logic [1:0] ModePwm   = 2'd3;

  if (PrescaleCycles < 1) begin : g_bad_prescale
    $error("led_controller: PrescaleCycles must be >= 1");
  end

  logic [PresWidth-1:0]   r_pres;
  logic [PresWidth-1:0]   w_pres_d;
  logic                   r_tick;
  logic                   r_ready;
  logic [DutyWidth-1:0]   r_phase;
  logic [NumLeds-1:0]     r_led;
  logic [NumLeds-1:0]     w_led_d;
  logic                   w_wr;

  logic [1:0]             r_mode   [NumLeds];
  logic [PeriodWidth-1:0] r_period [NumLeds];
  logic [DutyWidth-1:0]   r_duty   [NumLeds];
  logic [PeriodWidth-1:0] r_bcnt   [NumLeds];
  logic                   r_blink  [NumLeds];
  logic [1:0]             w_mode_d   [NumLeds];
  logic [PeriodWidth-1:0] w_period_d [NumLeds];
  logic [DutyWidth-1:0]   w_duty_d   [NumLeds];
  logic [PeriodWidth-1:0] w_bcnt_d   [NumLeds];
  logic                   w_blink_d  [NumLeds];
`ifdef LED_CONTROLLER_BREATHE_EN
  logic [DutyWidth-1:0]   r_wduty   [NumLeds];
  logic                   r_dir     [NumLeds];
  logic [DutyWidth-1:0]   w_wduty_d [NumLeds];
  logic                   w_dir_d   [NumLeds];
`endif

  assign w_wr     = cfg_valid_i && r_ready;
  assign w_pres_d = (r_pres == PresMax) ? '0 : r_pres + 1'b1;

  always_comb begin
    w_led_d = '0;
    for (int i = 0; i < NumLeds; i++) begin
      w_mode_d[i]   = r_mode[i];
      w_period_d[i] = r_period[i];
      w_duty_d[i]   = r_duty[i];
      w_bcnt_d[i]   = r_bcnt[i];
      w_blink_d[i]  = r_blink[i];
`ifdef LED_CONTROLLER_BREATHE_EN
      w_wduty_d[i]  = r_wduty[i];
      w_dir_d[i]    = r_dir[i];
`endif
      // A write to this channel overrides any tick arriving in the same cycle.
      if (w_wr && (cfg_chan_i == ChanWidth'(i))) begin
        w_mode_d[i]   = cfg_mode_i;
        w_period_d[i] = (cfg_period_i == '0) ? PeriodWidth'(1) : cfg_period_i;
        w_duty_d[i]   = cfg_duty_i;
        w_bcnt_d[i]   = '0;
        w_blink_d[i]  = 1'b0;
`ifdef LED_CONTROLLER_BREATHE_EN
        w_wduty_d[i]  = '0;
        w_dir_d[i]    = 1'b0;
`endif
      end else if (r_tick) begin
        if (r_mode[i] == ModeBlink) begin
          if (r_bcnt[i] == r_period[i] - 1'b1) begin
            w_bcnt_d[i]  = '0;
            w_blink_d[i] = ~r_blink[i];
          end else begin
            w_bcnt_d[i]  = r_bcnt[i] + 1'b1;
          end
        end
`ifdef LED_CONTROLLER_BREATHE_EN
        // Triangle ramp: up to the written duty, back down to 0, repeat.
        if (r_mode[i] == ModePwm) begin
          if (r_duty[i] == '0) begin
            w_wduty_d[i] = '0;
          end else if (!r_dir[i]) begin
            if (r_wduty[i] >= r_duty[i] - 1'b1) begin
              w_wduty_d[i] = r_duty[i];
              w_dir_d[i]   = 1'b1;
            end else begin
              w_wduty_d[i] = r_wduty[i] + 1'b1;
            end
          end else if (r_wduty[i] <= DutyWidth'(1)) begin
            w_wduty_d[i] = '0;
            w_dir_d[i]   = 1'b0;
          end else begin
            w_wduty_d[i] = r_wduty[i] - 1'b1;
          end
        end
`endif
      end

      case (w_mode_d[i])
        ModeOff:   w_led_d[i] = 1'b0;
        ModeOn:    w_led_d[i] = 1'b1;
        ModeBlink: w_led_d[i] = w_blink_d[i];
`ifdef LED_CONTROLLER_BREATHE_EN
        ModePwm:   w_led_d[i] = (r_phase < w_wduty_d[i]);
`else
        ModePwm:   w_led_d[i] = (r_phase < w_duty_d[i]);
`endif
        default:   w_led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pres  <= '0;
      r_tick  <= 1'b0;
      r_ready <= 1'b0;
      r_phase <= '0;
      r_led   <= '0;
      for (int i = 0; i < NumLeds; i++) begin
        r_mode[i]   <= ModeOff;
        r_period[i] <= PeriodWidth'(1);
        r_duty[i]   <= '0;
        r_bcnt[i]   <= '0;
        r_blink[i]  <= 1'b0;
`ifdef LED_CONTROLLER_BREATHE_EN
        r_wduty[i]  <= '0;
        r_dir[i]    <= 1'b0;
`endif
      end
    end else begin
      r_pres  <= w_pres_d;
      r_tick  <= (w_pres_d == PresMax);
      r_ready <= 1'b1;
      r_phase <= r_phase + 1'b1;
      r_led   <= w_led_d;
      for (int i = 0; i < NumLeds; i++) begin
        r_mode[i]   <= w_mode_d[i];
        r_period[i] <= w_period_d[i];
        r_duty[i]   <= w_duty_d[i];
        r_bcnt[i]   <= w_bcnt_d[i];
        r_blink[i]  <= w_blink_d[i];
`ifdef LED_CONTROLLER_BREATHE_EN
        r_wduty[i]  <= w_wduty_d[i];
        r_dir[i]    <= w_dir_d[i];
`endif
      end
    end
  end

  assign cfg_ready_o = r_ready;
  assign tick_o      = r_tick;
  assign led_o       = r_led;

endmodule

// File: tb/tb_led_controller.sv
// Self-checking bench for led_controller: directed scenarios plus randomized writes,
// all checked against an arithmetic reference model of the channel behaviour.
module tb_led_controller;
  localparam int unsigned NumLeds = 3;
  localparam int unsigned Presc   = 4;
  localparam int unsigned PerW    = 16;
  localparam int unsigned DutyW   = 8;
  localparam int          Frame   = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [1:0]        cfg_chan = '0;
  logic [1:0]        cfg_mode = '0;
  logic [PerW-1:0]   cfg_period = '0;
  logic [DutyW-1:0]  cfg_duty = '0;
  logic              ready;
  logic              tick;
  logic [NumLeds-1:0] led;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  led_controller #(
    .NumLeds       (NumLeds),
    .PrescaleCycles(Presc),
    .PeriodWidth   (PerW),
    .DutyWidth     (DutyW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (ready),
    .cfg_chan_i  (cfg_chan),
    .cfg_mode_i  (cfg_mode),
    .cfg_period_i(cfg_period),
    .cfg_duty_i  (cfg_duty),
    .tick_o      (tick),
    .led_o       (led)
  );

  // Reference model: elapsed edges and ticks-since-write, evaluated with plain arithmetic.
  int m_n;
  bit m_ready;
  int m_mode   [NumLeds];
  int m_period [NumLeds];
  int m_duty   [NumLeds];
  int m_tsince [NumLeds];
  logic [NumLeds-1:0] exp_led = '0;
  logic exp_tick = 1'b0;
  logic exp_ready = 1'b0;
  bit   mb_tick;
  bit   mb_wr;
  int   mb_phase;

  function automatic int eff_duty(input int d, input int t);
`ifdef LED_CONTROLLER_BREATHE_EN
    int m;
    if (d == 0) return 0;
    m = t % (2 * d);
    return (m <= d) ? m : 2 * d - m;
`else
    if (t < 0) return 0;
    return d;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_n = 0;
      m_ready = 1'b0;
      for (int c = 0; c < NumLeds; c++) begin
        m_mode[c] = 0; m_period[c] = 1; m_duty[c] = 0; m_tsince[c] = 0;
      end
      exp_led = '0; exp_tick = 1'b0; exp_ready = 1'b0;
    end else begin
      mb_tick  = (m_n % Presc) == Presc - 1;
      mb_phase = m_n % Frame;
      mb_wr    = cfg_valid && m_ready;
      for (int c = 0; c < NumLeds; c++) begin
        if (mb_wr && int'(cfg_chan) == c) begin
          m_mode[c]   = int'(cfg_mode);
          m_period[c] = (cfg_period == '0) ? 1 : int'(cfg_period);
          m_duty[c]   = int'(cfg_duty);
          m_tsince[c] = 0;
        end else if (mb_tick) begin
          m_tsince[c]++;
        end
        case (m_mode[c])
          0: exp_led[c] = 1'b0;
          1: exp_led[c] = 1'b1;
          2: exp_led[c] = ((m_tsince[c] / m_period[c]) % 2 == 1) ? 1'b1 : 1'b0;
          default: exp_led[c] = (mb_phase < eff_duty(m_duty[c], m_tsince[c])) ? 1'b1 : 1'b0;
        endcase
      end
      m_n++;
      m_ready   = 1'b1;
      exp_ready = 1'b1;
      exp_tick  = ((m_n % Presc) == Presc - 1) ? 1'b1 : 1'b0;
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_cfg(input int ch, input int mode, input int period, input int duty);
    cfg_valid  = 1'b1;
    cfg_chan   = 2'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = PerW'(period);
    cfg_duty   = DutyW'(duty);
    cycle();
    cfg_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      cycle();
      checks++; if (led !== '0) $display("FAIL reset_led got=%b want=0", led); else passed++;
      checks++; if (tick !== 1'b0) $display("FAIL reset_tick got=%b want=0", tick); else passed++;
      checks++; if (ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", ready); else passed++;
    end
    rst_n = 1'b1;
    cycle();
    checks++; if (ready !== 1'b1) $display("FAIL ready_after_release got=%b want=1", ready);
    else passed++;
    checks++; if (led !== '0) $display("FAIL led_after_release got=%b want=0", led); else passed++;
  endtask

  // Must follow test_reset directly: one edge has elapsed since release.
  task automatic test_prescaler_on();
    for (int e = 2; e <= 12; e++) begin
      cycle();
      checks++;
      if (tick !== ((e % 4 == 3) ? 1'b1 : 1'b0))
        $display("FAIL prescaler_tick edge=%0d got=%b want=%b", e, tick, (e % 4 == 3));
      else passed++;
    end
    write_cfg(0, 1, 0, 0);
    checks++; if (led[0] !== 1'b1) $display("FAIL on_write got=%b want=1", led[0]); else passed++;
    checks++; if (led !== exp_led) $display("FAIL on_model got=%b want=%b", led, exp_led);
    else passed++;
  endtask

  task automatic measure_level(input string name, input int want);
    logic prev;
    int   len;
    prev = led[1];
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (led[1] !== prev) break;
    end
    prev = led[1];
    len  = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      len++;
      if (led[1] !== prev) break;
    end
    checks++; if (len != want) $display("FAIL %s level_len got=%0d want=%0d", name, len, want);
    else passed++;
  endtask

  task automatic test_blink();
    write_cfg(1, 2, 3, 0);
    for (int i = 0; i < 30; i++) begin
      checks++; if (led !== exp_led) $display("FAIL blink3_model got=%b want=%b", led, exp_led);
      else passed++;
      cycle();
    end
    measure_level("blink_p3", 12);
    write_cfg(1, 2, 0, 0);
    checks++; if (led[1] !== 1'b0) $display("FAIL blink_rewrite_clear got=%b want=0", led[1]);
    else passed++;
    measure_level("blink_p0", 4);
  endtask

  task automatic test_pwm();
    int duties[3] = '{64, 0, 255};
    int cnt;
    foreach (duties[k]) begin
      write_cfg(2, 3, 0, duties[k]);
      cnt = 0;
      for (int i = 0; i < Frame; i++) begin
        if (led[2] === 1'b1) cnt++;
        checks++; if (led !== exp_led) $display("FAIL pwm_model got=%b want=%b", led, exp_led);
        else passed++;
        cycle();
      end
`ifndef LED_CONTROLLER_BREATHE_EN
      checks++;
      if (cnt != duties[k]) $display("FAIL pwm_high_count got=%0d want=%0d", cnt, duties[k]);
      else passed++;
`endif
    end
  endtask

  task automatic test_out_of_range();
    for (int c = 0; c < NumLeds; c++) write_cfg(c, 0, 1, 0);
    checks++; if (ready !== 1'b1) $display("FAIL oor_ready got=%b want=1", ready); else passed++;
    write_cfg(3, 1, 5, 200);
    for (int i = 0; i < 8; i++) begin
      checks++; if (led !== 3'b000) $display("FAIL oor_dropped got=%b want=000", led);
      else passed++;
      cycle();
    end
  endtask

  task automatic test_collision();
    bit found;
    write_cfg(1, 2, 1, 0);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tick === 1'b1) begin found = 1'b1; break; end
      cycle();
    end
    checks++; if (!found) $display("FAIL collision_tick_wait got=timeout want=tick"); else passed++;
    write_cfg(1, 2, 2, 0);
    for (int k = 0; k <= 8; k++) begin
      checks++;
      if (led[1] !== ((k == 8) ? 1'b1 : 1'b0))
        $display("FAIL collision k=%0d got=%b want=%b", k, led[1], (k == 8));
      else passed++;
      checks++; if (led !== exp_led) $display("FAIL collision_model got=%b want=%b", led, exp_led);
      else passed++;
      cycle();
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 600; i++) begin
      checks++; if (led !== exp_led) $display("FAIL rand_led got=%b want=%b", led, exp_led);
      else passed++;
      checks++; if (tick !== exp_tick) $display("FAIL rand_tick got=%b want=%b", tick, exp_tick);
      else passed++;
      checks++; if (ready !== exp_ready) $display("FAIL rand_ready got=%b want=%b", ready, exp_ready);
      else passed++;
      cfg_valid  = ($urandom % 6) == 0;
      cfg_chan   = 2'($urandom % 4);
      cfg_mode   = 2'($urandom % 4);
      cfg_period = PerW'($urandom % 4);
      r = int'($urandom % 4);
      cfg_duty   = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom);
      cycle();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_midreset();
    write_cfg(1, 2, 1, 0);
    write_cfg(0, 1, 0, 0);
    repeat (9) cycle();
    rst_n = 1'b0;
    cycle();
    checks++; if (led !== '0) $display("FAIL midreset_led got=%b want=0", led); else passed++;
    checks++; if (tick !== 1'b0) $display("FAIL midreset_tick got=%b want=0", tick); else passed++;
    checks++; if (ready !== 1'b0) $display("FAIL midreset_ready got=%b want=0", ready); else passed++;
    rst_n = 1'b1;
    cycle();
    checks++; if (ready !== 1'b1) $display("FAIL midreset_release got=%b want=1", ready);
    else passed++;
    checks++; if (led !== exp_led) $display("FAIL midreset_model got=%b want=%b", led, exp_led);
    else passed++;
  endtask

`ifdef LED_CONTROLLER_BREATHE_EN
  task automatic test_breathe();
    write_cfg(2, 3, 0, 4);
    for (int i = 0; i < 3 * Frame; i++) begin
      checks++; if (led !== exp_led) $display("FAIL breathe_model got=%b want=%b", led, exp_led);
      else passed++;
      cycle();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_prescaler_on();
    test_blink();
    test_pwm();
    test_out_of_range();
    test_collision();
`ifdef LED_CONTROLLER_BREATHE_EN
    test_breathe();
`endif
    test_random();
    test_midreset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
